// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests instruction words from memory, presents them
// to the decoder with a valid/ready handshake and computes the next fetch pc
// from branch, jump and register-jump controls, with external flush redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  funcode,
    output logic [4:0]  rt,
    output logic [5:0]  specialcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        Branch,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        addr_err,
    output logic [31:0] instr_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [XLEN-1:0]   r_pc,         w_pc_nxt;
    logic [XLEN-1:0]   r_pc_plus4;
    logic [XLEN-1:0]   r_flush_pc,   w_flush_pc_nxt;
    logic [XLEN-1:0]   r_instr,      w_instr_nxt;
    logic [XLEN-1:0]   r_count,      w_count_nxt;
    logic              r_valid,      w_valid_nxt;
    logic              r_req,        w_req_nxt;
    logic              r_addr_err,   w_addr_err_nxt;
    logic [XLEN-1:0]   w_target;

    // Redirect target for the presented instruction, highest priority first.
    always_comb begin
        if (jumpReg) begin
            w_target = jr_target;
        end else if (jump) begin
            w_target = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (Branch && branch_taken) begin
            w_target = r_pc_plus4 + (branch_offset << 2);
        end else begin
            w_target = r_pc_plus4;
        end
    end

    // Next-state and next-value logic; flush outranks every other event.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_flush_pc_nxt = r_flush_pc;
        w_instr_nxt    = r_instr;
        w_count_nxt    = r_count;
        w_valid_nxt    = r_valid;
        w_addr_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (flush) begin
                    w_pc_nxt = flush_pc;
                end
            end
            FETCH: begin
                if (flush) begin
                    if (imem_ack) begin
                        w_pc_nxt = flush_pc;
                    end else begin
                        w_flush_pc_nxt = flush_pc;
                        w_state_nxt    = DRAIN;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = flush_pc;
                    w_state_nxt = FETCH;
                end else if (instr_ready) begin
                    w_valid_nxt    = 1'b0;
                    w_pc_nxt       = {w_target[XLEN-1:2], 2'b00};
                    w_addr_err_nxt = |w_target[1:0];
                    w_count_nxt    = r_count + XLEN'(1);
                    w_state_nxt    = FETCH;
                end
            end
            DRAIN: begin
                // The outstanding word is discarded; a same-cycle flush wins.
                if (imem_ack) begin
                    w_pc_nxt    = flush ? flush_pc : r_flush_pc;
                    w_state_nxt = FETCH;
                end else if (flush) begin
                    w_flush_pc_nxt = flush_pc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_req_nxt = (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + XLEN'(4);
            r_flush_pc <= '0;
            r_instr    <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_plus4 <= w_pc_nxt + XLEN'(4);
            r_flush_pc <= w_flush_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= w_valid_nxt;
            r_req      <= w_req_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign funcode     = r_instr[31:26];
    assign rt          = r_instr[20:16];
    assign specialcode = r_instr[5:0];
    assign pc_out      = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign addr_err    = r_addr_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: a transaction-level model predicts
// fetch addresses and presented instructions; a monitor compares DUT output.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc_out, pc_plus4;
    logic [5:0]  funcode, specialcode;
    logic [4:0]  rt;
    logic        Branch, jump, jumpReg, branch_taken;
    logic [31:0] branch_offset, jr_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        addr_err;
    logic [31:0] instr_count;

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .funcode(funcode), .rt(rt), .specialcode(specialcode),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .Branch(Branch), .jump(jump), .jumpReg(jumpReg), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jr_target(jr_target),
        .flush(flush), .flush_pc(flush_pc),
        .addr_err(addr_err), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic err; } fetch_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] word; logic [31:0] count; } pres_t;

    fetch_t q_fetch[$];
    pres_t  q_instr[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: address of the fetch in flight, pending redirect, presented word.
    logic [31:0] m_cur, m_target, m_ppc, m_pinstr, m_count;
    logic        m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic e);
        fetch_t f;
        f.addr = a;
        f.err  = e;
        q_fetch.push_back(f);
        m_cur = a;
    endtask

    // Predict what the coming clock edge does, from the spec's transaction rules.
    task automatic model_step();
        logic [31:0] p4, t;
        pres_t p;
        if (imem_req) begin
            if (flush && imem_ack) begin
                push_fetch(flush_pc, 1'b0);
                m_drop = 1'b0;
            end else if (flush) begin
                m_drop   = 1'b1;
                m_target = flush_pc;
            end else if (imem_ack) begin
                if (m_drop) begin
                    push_fetch(m_target, 1'b0);
                    m_drop = 1'b0;
                end else begin
                    m_ppc    = m_cur;
                    m_pinstr = imem_rdata;
                    p.addr = m_cur; p.word = imem_rdata; p.count = m_count;
                    q_instr.push_back(p);
                end
            end
        end else if (instr_valid) begin
            if (flush) begin
                push_fetch(flush_pc, 1'b0);
            end else if (instr_ready) begin
                p4 = m_ppc + 32'd4;
                if (jumpReg)                    t = jr_target;
                else if (jump)                  t = {p4[31:28], m_pinstr[25:0], 2'b00};
                else if (Branch && branch_taken) t = p4 + branch_offset * 32'd4;
                else                            t = p4;
                m_count = m_count + 32'd1;
                push_fetch(t & 32'hFFFF_FFFC, t[1:0] != 2'b00);
            end
        end else begin
            push_fetch(flush ? flush_pc : RESET_PC, 1'b0);
        end
    endtask

    task automatic drive_random();
        int o;
        logic [31:0] r;
        imem_ack     = ($urandom_range(0, 99) < 45);
        imem_rdata   = $urandom();
        instr_ready  = ($urandom_range(0, 99) < 60);
        flush        = ($urandom_range(0, 99) < 6);
        r = $urandom();
        case ($urandom_range(0, 2))
            0:       flush_pc = 32'h0000_5000;
            1:       flush_pc = 32'hFFFF_FFFC;
            default: flush_pc = r & 32'hFFFF_FFFC;
        endcase
        jumpReg      = ($urandom_range(0, 7) == 0);
        jump         = ($urandom_range(0, 5) == 0);
        Branch       = ($urandom_range(0, 2) == 0);
        branch_taken = $urandom_range(0, 1) == 1;
        o = $urandom_range(0, 64);
        branch_offset = 32'(o - 32);
        r = $urandom();
        if ($urandom_range(0, 3) != 0) r = r & 32'hFFFF_FFFC;
        jr_target = r;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive_random();
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_count"}, instr_count,          32'd0);
        chk({tag, "_err"},   {31'd0, addr_err},    32'd0);
        chk({tag, "_addr"},  imem_addr,            RESET_PC);
        chk({tag, "_instr"}, instr,                32'd0);
    endtask

    // Monitor: pops expectations when a new request or presentation appears.
    logic        l_req, l_valid;
    logic [31:0] l_addr, l_instr, l_pc;
    initial begin
        fetch_t f;
        pres_t  p;
        logic   new_req;
        l_req = 1'b0; l_valid = 1'b0; l_addr = '0; l_instr = '0; l_pc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                l_req = 1'b0;
                l_valid = 1'b0;
                continue;
            end
            new_req = imem_req && (!l_req || imem_ack);
            if (new_req) begin
                if (q_fetch.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                end else begin
                    f = q_fetch.pop_front();
                    chk("fetch_addr", imem_addr, f.addr);
                    chk("addr_err", {31'd0, addr_err}, {31'd0, f.err});
                end
            end else begin
                chk("addr_err_idle", {31'd0, addr_err}, 32'd0);
                if (imem_req) chk("addr_stable", imem_addr, l_addr);
            end
            if (instr_valid && !l_valid) begin
                if (q_instr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_instr: got %h expected no instruction", instr);
                end else begin
                    p = q_instr.pop_front();
                    chk("instr",       instr,                 p.word);
                    chk("pc_out",      pc_out,                p.addr);
                    chk("pc_plus4",    pc_plus4,              p.addr + 32'd4);
                    chk("funcode",     {26'd0, funcode},      {26'd0, p.word[31:26]});
                    chk("rt",          {27'd0, rt},           {27'd0, p.word[20:16]});
                    chk("specialcode", {26'd0, specialcode},  {26'd0, p.word[5:0]});
                    chk("instr_count", instr_count,           p.count);
                end
            end else if (instr_valid) begin
                chk("hold_instr", instr,  l_instr);
                chk("hold_pc",    pc_out, l_pc);
            end
            if (instr_valid) chk("hold_no_req", {31'd0, imem_req}, 32'd0);
            l_req   = imem_req;
            l_valid = instr_valid;
            l_addr  = imem_addr;
            l_instr = instr;
            l_pc    = pc_out;
        end
    end

    // Driver: reset, random phase, reset while holding, random phase, drain.
    initial begin
        int budget;
        rst = 1'b1;
        imem_ack = 0; imem_rdata = '0; instr_ready = 0; flush = 0; flush_pc = '0;
        Branch = 0; jump = 0; jumpReg = 0; branch_taken = 0; branch_offset = '0; jr_target = '0;
        m_cur = '0; m_target = '0; m_ppc = '0; m_pinstr = '0; m_count = '0; m_drop = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        rst = 1'b0;
        run_random(1500);

        budget = 0;
        while (!instr_valid && budget < 200) begin
            drive_random();
            model_step();
            @(negedge clk);
            budget++;
        end
        n_cmp++;
        if (!instr_valid) begin
            n_fail++;
            $display("FAIL hold_search: got no instruction within %0d cycles", budget);
        end
        instr_ready = 1'b0;
        flush = 1'b0;
        model_step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_hold");
        q_fetch.delete();
        q_instr.delete();
        m_drop = 1'b0;
        m_count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_random(1500);

        for (int i = 0; i < 12; i++) begin
            drive_random();
            imem_ack = 1'b1;
            instr_ready = 1'b0;
            flush = 1'b0;
            model_step();
            @(negedge clk);
        end
        chk("fetch_q_empty", q_fetch.size(), 32'd0);
        chk("instr_q_empty", q_instr.size(), 32'd0);
        chk("final_valid", {31'd0, instr_valid}, 32'd1);
        chk("final_count", instr_count, m_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
